// File: rtl/neg_abs_serial.sv
// neg_abs_serial
//   Serial pass / negate / absolute value / negative absolute value unit.
//   An accepted operand is conditionally inverted, and the +1 of the two's-
//   complement negation rippled through a half-adder chain CHUNK bits per
//   clock, LSB chunk first. A 1-bit carry register links the chunks.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   data_i/mode_i valid
//   in_ready   out  block idle, can accept an operand
//   data_i     in   WIDTH  two's-complement operand
//   mode_i     in   2      00 pass, 01 negate, 10 abs, 11 negative abs
//   out_valid  out  res_o/ovf_o/zero_o valid
//   out_ready  in   consumer takes the result
//   res_o      out  WIDTH  result (0 while out_valid is low)
//   ovf_o      out  result not representable (negating the most negative value)
//   zero_o     out  res_o == 0
module neg_abs_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned CH  = CHUNK;
  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;   // operand, overwritten chunk by chunk with the result
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             sign_in;
  logic             neg_in;
  logic [CH-1:0]    chunk_cur;
  logic [CH-1:0]    chunk_opnd;
  logic [CH-1:0]    chunk_sum;
  logic             chunk_cout;

  always_comb begin
    sign_in = data_i[WIDTH-1];
    neg_in  = (mode_i == 2'b01)
            | ((mode_i == 2'b10) &  sign_in)
            | ((mode_i == 2'b11) & ~sign_in);
  end

  // Half-adder chain over the chunk selected by cnt_q.
  always_comb begin
    logic c;
    chunk_cur = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(cnt_q) == k) chunk_cur = data_q[k*CH +: CH];
    end
    chunk_opnd = neg_q ? ~chunk_cur : chunk_cur;
    c = carry_q;
    for (int unsigned b = 0; b < CH; b++) begin
      chunk_sum[b] = chunk_opnd[b] ^ c;
      c            = chunk_opnd[b] & c;
    end
    chunk_cout = c;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = data_i;
          neg_d   = neg_in;
          carry_d = neg_in;
          cnt_d   = '0;
          ovf_d   = neg_in && (data_i == {1'b1, {(WIDTH-1){1'b0}}});
          state_d = CALC;
        end
      end
      CALC: begin
        for (int unsigned k = 0; k < NCH; k++) begin
          if (32'(cnt_q) == k) data_d[k*CH +: CH] = chunk_sum;
        end
        carry_d = chunk_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NCH - 1)) begin
          // carry out of the top chunk is dropped (modulo 2^WIDTH)
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result outputs are gated by DONE so partial chunks never show.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    res_o     = out_valid ? data_q : '0;
    ovf_o     = out_valid & ovf_q;
    zero_o    = out_valid & (data_q == '0);
  end

endmodule

// File: tb/tb_neg_abs_serial.sv
module tb_neg_abs_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_i;
  logic [1:0]  mode_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res_o;
  logic        ovf_o;
  logic        zero_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neg_abs_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_i    (data_i),
    .mode_i    (mode_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_o     (res_o),
    .ovf_o     (ovf_o),
    .zero_o    (zero_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: neg decision and arithmetic negation modulo 2^16.
  task automatic model(input logic [15:0] d, input logic [1:0] m,
                       output logic [15:0] r, output logic o, output logic z);
    logic n;
    n = (m == 2'b01) || (m == 2'b10 && d[15]) || (m == 2'b11 && !d[15]);
    r = n ? 16'(0 - int'(d)) : d;
    o = n && (d == 16'h8000);
    z = (r == 16'h0000);
  endtask

  // One operand through the block; hold = cycles of out_ready=0 in DONE.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] m,
                        input logic [15:0] er, input logic eo, input logic ez,
                        input int hold);
    int lat;
    logic [15:0] held;
    check({tag, ":in_ready_before"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    data_i    = d;
    mode_i    = m;
    step();                                    // accept edge
    in_valid  = 1'b0;
    data_i    = ~d;                            // must not disturb the result
    mode_i    = ~m;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'd4);
    check({tag, ":res"},  32'(res_o),  32'(er));
    check({tag, ":ovf"},  32'(ovf_o),  32'(eo));
    check({tag, ":zero"}, 32'(zero_o), 32'(ez));
    held = res_o;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;                         // ignored outside IDLE
      data_i   = 16'(i * 16'h1111);
      step();
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_res"},   32'(res_o),     32'(held));
      check({tag, ":hold_ready"}, 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();                                    // release edge
    check({tag, ":released"}, 32'(out_valid), 32'd0);
    check({tag, ":idle"},     32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [15:0] r;
    logic        o;
    logic        z;
    logic [15:0] d;
    logic [1:0]  m;

    rst       = 1'b1;
    in_valid  = 1'b0;
    data_i    = 16'h0;
    mode_i    = 2'b00;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset:in_ready",  32'(in_ready),  32'd1);
    check("reset:out_valid", 32'(out_valid), 32'd0);
    check("reset:res",       32'(res_o),     32'd0);
    check("reset:ovf",       32'(ovf_o),     32'd0);
    check("reset:zero",      32'(zero_o),    32'd0);

    run_op("neg_0001",    16'h0001, 2'b01, 16'hFFFF, 1'b0, 1'b0, 0);
    run_op("neg_0000",    16'h0000, 2'b01, 16'h0000, 1'b0, 1'b1, 0);
    run_op("abs_8000",    16'h8000, 2'b10, 16'h8000, 1'b1, 1'b0, 0);
    run_op("abs_fffb",    16'hFFFB, 2'b10, 16'h0005, 1'b0, 1'b0, 0);
    run_op("abs_7fff",    16'h7FFF, 2'b10, 16'h7FFF, 1'b0, 1'b0, 0);
    run_op("nabs_0005",   16'h0005, 2'b11, 16'hFFFB, 1'b0, 1'b0, 0);
    run_op("nabs_8000",   16'h8000, 2'b11, 16'h8000, 1'b0, 1'b0, 0);
    run_op("pass_1234",   16'h1234, 2'b00, 16'h1234, 1'b0, 1'b0, 0);
    run_op("neg_8000",    16'h8000, 2'b01, 16'h8000, 1'b1, 1'b0, 0);
    run_op("nabs_0000",   16'h0000, 2'b11, 16'h0000, 1'b0, 1'b1, 0);
    run_op("neg_00f0",    16'h00F0, 2'b01, 16'hFF10, 1'b0, 1'b0, 0);
    run_op("bp_neg_1234", 16'h1234, 2'b01, 16'hEDCC, 1'b0, 1'b0, 3);

    // Reset during the second CALC cycle aborts with no output pulse.
    in_valid = 1'b1;
    data_i   = 16'h0001;
    mode_i   = 2'b01;
    step();                                    // accept
    in_valid = 1'b0;
    step();                                    // now in 2nd CALC cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort:in_ready",  32'(in_ready),  32'd1);
    check("abort:out_valid", 32'(out_valid), 32'd0);
    check("abort:res",       32'(res_o),     32'd0);
    check("abort:ovf",       32'(ovf_o),     32'd0);
    check("abort:zero",      32'(zero_o),    32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort:no_pulse", 32'(out_valid), 32'd0);
    end
    run_op("after_abort", 16'hFFFB, 2'b10, 16'h0005, 1'b0, 1'b0, 0);

    // Random sweep with idle gaps and backpressure.
    for (int n = 0; n < 24; n++) begin
      d = 16'($urandom);
      m = 2'($urandom_range(3, 0));
      if (n % 6 == 0) d = 16'h8000;
      model(d, m, r, o, z);
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
        step();
        check("rand:gap_valid", 32'(out_valid), 32'd0);
      end
      run_op("rand", d, m, r, o, z, int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neg_abs_serial.md
NEG_ABS_SERIAL -- requirements
Module: neg_abs_serial

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and result width in bits; legal when WIDTH >= 4 and WIDTH is a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, SHALL set the bits processed per clock by the internal increment chain; N = WIDTH/CHUNK.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  SHALL flag that data_i and mode_i are valid.
REQ-006 in_ready  output  1  SHALL flag that the block can accept an operand.
REQ-007 data_i  input  WIDTH  SHALL be the two's-complement operand.
REQ-008 mode_i  input  2  SHALL select the operation: 00 pass, 01 negate, 10 absolute value, 11 negative absolute value.
REQ-009 out_valid  output  1  SHALL flag that res_o, ovf_o and zero_o are valid.
REQ-010 out_ready  input  1  SHALL flag that the consumer takes the result.
REQ-011 res_o  output  WIDTH  SHALL be the two's-complement result.
REQ-012 ovf_o  output  1  SHALL flag that the true result is not representable in WIDTH bits.
REQ-013 zero_o  output  1  SHALL flag res_o == 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Handshake: a transfer SHALL occur on an edge where in_valid && in_ready; the block SHALL register data_i and mode_i, clear its chunk counter and move IDLE -> CALC.
REQ-017 The negate decision SHALL be neg = (mode==01) | (mode==10 & sign) | (mode==11 & ~sign), where sign = data_i[WIDTH-1].
REQ-018 Result: if neg, res = (~data) + 1, computed modulo 2^WIDTH; otherwise res = data.
REQ-019 The +1 SHALL be built as a half-adder carry chain with no full adder or multiplier. In CALC it SHALL process exactly CHUNK bits per cycle, LSB chunk first.
REQ-020 A 1-bit carry register SHALL link chunks. It SHALL be initialised to 1 when neg and 0 otherwise. The carry out of the top chunk SHALL be discarded.
REQ-021 The block SHALL stay in CALC for exactly N edges, then move CALC -> DONE. out_valid SHALL first be 1 after the Nth edge following the accept edge (4 edges for the default parameters).
REQ-022 ovf_o SHALL be neg && (data == 1 followed by WIDTH-1 zeros). For this case res_o SHALL equal the input, with no saturation.
REQ-023 zero_o SHALL equal (res_o == 0) and SHALL be valid together with out_valid.
REQ-024 In DONE, res_o, ovf_o and zero_o SHALL hold stable until out_valid && out_ready. On that edge the FSM SHALL move DONE -> IDLE.
REQ-025 in_valid SHALL be ignored outside IDLE; data_i and mode_i changes during CALC/DONE SHALL NOT affect the result.
REQ-026 Peak throughput SHALL be one operand per N+2 cycles. The block SHALL NOT accept a new operand in the same cycle it releases a result.

Reset
REQ-027 While rst is 1 at a clock edge, the block SHALL move the FSM to IDLE and clear the chunk counter and carry. rst SHALL take priority over all handshakes.
REQ-028 Reset values SHALL be: in_ready=1 from the first cycle after reset; out_valid=0; res_o=0; ovf_o=0; zero_o=0.
REQ-029 A reset asserted during CALC or DONE SHALL abort the operation with no out_valid pulse. Partial results SHALL NOT leak.

Verification (WIDTH=16, CHUNK=4)
REQ-030 Negate 0x0001 (mode 01), out_ready=1 -> res_o=0xFFFF, ovf_o=0, zero_o=0; out_valid high 4 edges after the accept edge.
REQ-031 Negate 0x0000 (carry ripples through all 4 chunks) -> res_o=0x0000, zero_o=1, ovf_o=0. Abs 0x8000 -> res_o=0x8000, ovf_o=1.
REQ-032 Abs 0xFFFB -> 0x0005. Abs 0x7FFF -> 0x7FFF. Neg-abs 0x0005 -> 0xFFFB. Neg-abs 0x8000 -> 0x8000 with ovf_o=0. Pass 0x1234 -> 0x1234.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles in DONE -> res_o stable, in_ready=0, and in_valid pulses are ignored; then out_ready=1 -> one transfer and return to IDLE.
REQ-034 Assert rst on the 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, all outputs 0; a fresh operand then completes correctly.
REQ-035 Random sweep of data/mode with random in_valid/out_ready -> every result matches the model in REQ-017/018/022. No lost or duplicated transfers.
